// File: rtl/sram_march_bist_if.sv
// Shared port-0 SRAM bus plus BIST request/status bundle between the sequencer and the wrapper.
interface sram_march_bist_if #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WMASK_WIDTH = 4,
    parameter int unsigned NUM_SRAMS   = 16,
    parameter int unsigned SEL_WIDTH   = 4
);
    logic                   start;
    logic                   abort;
    logic [SEL_WIDTH-1:0]   sram_sel;
    logic [ADDR_WIDTH-1:0]  addr_max;
    logic [DATA_WIDTH-1:0]  cmp_mask;
    logic [DATA_WIDTH-1:0]  rdata;
    logic [ADDR_WIDTH-1:0]  addr0;
    logic [DATA_WIDTH-1:0]  din0;
    logic                   web0;
    logic [WMASK_WIDTH-1:0] wmask0;
    logic [NUM_SRAMS-1:0]   csb0;
    logic [NUM_SRAMS-1:0]   csb1;
    logic                   bist_active;
    logic                   done;
    logic                   pass;
    logic [ADDR_WIDTH-1:0]  fail_addr;
    logic [2:0]             fail_elem;
    logic [DATA_WIDTH-1:0]  fail_data;
    logic [15:0]            err_count;

    modport master (
        input  start, abort, sram_sel, addr_max, cmp_mask, rdata,
        output addr0, din0, web0, wmask0, csb0, csb1, bist_active,
               done, pass, fail_addr, fail_elem, fail_data, err_count
    );

    modport slave (
        output start, abort, sram_sel, addr_max, cmp_mask, rdata,
        input  addr0, din0, web0, wmask0, csb0, csb1, bist_active,
               done, pass, fail_addr, fail_elem, fail_data, err_count
    );
endinterface

// File: rtl/sram_march_bist.sv
// March C- sequencer: drives one OpenRAM macro over the shared port-0 bus, compares the
// captured read data and reports pass/fail, first failing location and a saturating error count.
module sram_march_bist #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WMASK_WIDTH = 4,
    parameter int unsigned NUM_SRAMS   = 16,
    parameter int unsigned SEL_WIDTH   = 4,
    parameter int unsigned READ_LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    sram_march_bist_if.master bus
);
    localparam int unsigned ELEM_W  = 3;
    localparam int unsigned DRAIN_W = 3;
    localparam int unsigned ERR_W   = 16;
    localparam logic [ELEM_W-1:0] ELEM_END = ELEM_W'(6);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [ELEM_W-1:0]       r_elem, w_elem_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
    logic                    r_phase, w_phase_nxt;
    logic [SEL_WIDTH-1:0]    r_sel, w_sel_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr_max, w_amax_nxt;
    logic [DATA_WIDTH-1:0]   r_cmp_mask, w_mask_nxt;
    logic [DRAIN_W-1:0]      r_drain, w_drain_nxt;
    logic                    r_op_rd, w_op_rd_nxt;
    logic                    r_op_exp, w_op_exp_nxt;
    logic [ELEM_W-1:0]       r_op_elem, w_op_elem_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr0, w_addr0_nxt;
    logic [DATA_WIDTH-1:0]   r_din0, w_din0_nxt;
    logic                    r_web0, w_web0_nxt;
    logic [NUM_SRAMS-1:0]    r_csb0, w_csb0_nxt;
    logic                    r_active, w_active_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_pass, w_pass_nxt;
    logic [ADDR_WIDTH-1:0]   r_fail_addr, w_fail_addr_nxt;
    logic [ELEM_W-1:0]       r_fail_elem, w_fail_elem_nxt;
    logic [DATA_WIDTH-1:0]   r_fail_data, w_fail_data_nxt;
    logic [ERR_W-1:0]        r_err_count, w_err_nxt;
    logic                    w_flush;

    // Compare pipeline: one stage per cycle of read latency after the op leaves the bus
    logic [READ_LAT-1:0]     r_pv, r_pexp;
    logic [ADDR_WIDTH-1:0]   r_paddr [READ_LAT];
    logic [ELEM_W-1:0]       r_pelem [READ_LAT];
    logic                    w_mis;

    // Op generator: current op and its successor; seeded with E0/addr 0 when starting
    logic                    w_g_run, w_g_phase, w_g_down, w_g_single, w_g_rd, w_g_exp, w_g_wbit, w_g_end;
    logic [ELEM_W-1:0]       w_g_elem, w_s_elem;
    logic [ADDR_WIDTH-1:0]   w_g_addr, w_g_amax, w_s_addr;
    logic [SEL_WIDTH-1:0]    w_g_sel;
    logic                    w_s_phase;

    always_comb begin
        w_g_run    = (r_state == S_RUN);
        w_g_elem   = w_g_run ? r_elem : '0;
        w_g_addr   = w_g_run ? r_addr : '0;
        w_g_phase  = w_g_run ? r_phase : 1'b0;
        w_g_amax   = w_g_run ? r_addr_max : bus.addr_max;
        w_g_sel    = w_g_run ? r_sel : bus.sram_sel;
        w_g_down   = (w_g_elem >= ELEM_W'(3));
        w_g_single = (w_g_elem == ELEM_W'(0)) || (w_g_elem == ELEM_W'(5));
        w_g_rd     = (w_g_elem != ELEM_W'(0)) && (w_g_single || !w_g_phase);
        w_g_exp    = (w_g_elem == ELEM_W'(2)) || (w_g_elem == ELEM_W'(4));
        w_g_wbit   = (w_g_elem == ELEM_W'(1)) || (w_g_elem == ELEM_W'(3));
        w_g_end    = w_g_down ? (w_g_addr == '0) : (w_g_addr == w_g_amax);
        w_s_elem   = w_g_elem;
        w_s_addr   = w_g_addr;
        w_s_phase  = 1'b1;
        if (w_g_single || w_g_phase) begin
            w_s_phase = 1'b0;
            if (!w_g_end) begin
                w_s_addr = w_g_down ? (w_g_addr - ADDR_WIDTH'(1)) : (w_g_addr + ADDR_WIDTH'(1));
            end else begin
                w_s_elem = w_g_elem + ELEM_W'(1);
                w_s_addr = (w_g_elem >= ELEM_W'(2)) ? w_g_amax : '0;
            end
        end
    end

    assign w_mis = r_pv[READ_LAT-1] &&
                   (|((bus.rdata ^ {DATA_WIDTH{r_pexp[READ_LAT-1]}}) & r_cmp_mask));

    always_comb begin
        w_state_nxt     = r_state;
        w_elem_nxt      = r_elem;
        w_addr_nxt      = r_addr;
        w_phase_nxt     = r_phase;
        w_sel_nxt       = r_sel;
        w_amax_nxt      = r_addr_max;
        w_mask_nxt      = r_cmp_mask;
        w_drain_nxt     = r_drain;
        w_op_rd_nxt     = 1'b0;
        w_op_exp_nxt    = 1'b0;
        w_op_elem_nxt   = '0;
        w_addr0_nxt     = '0;
        w_din0_nxt      = '0;
        w_web0_nxt      = 1'b1;
        w_csb0_nxt      = '1;
        w_active_nxt    = 1'b0;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_fail_addr_nxt = r_fail_addr;
        w_fail_elem_nxt = r_fail_elem;
        w_fail_data_nxt = r_fail_data;
        w_err_nxt       = r_err_count;
        w_flush         = 1'b0;

        if ((r_state == S_RUN || r_state == S_DRAIN) && !bus.abort && w_mis) begin
            if (r_err_count != '1) w_err_nxt = r_err_count + ERR_W'(1);
            if (r_err_count == '0) begin
                w_fail_addr_nxt = r_paddr[READ_LAT-1];
                w_fail_elem_nxt = r_pelem[READ_LAT-1];
                w_fail_data_nxt = bus.rdata;
            end
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (!bus.abort && bus.start && (32'(bus.sram_sel) < NUM_SRAMS)) begin
                    w_state_nxt     = S_RUN;
                    w_sel_nxt       = bus.sram_sel;
                    w_amax_nxt      = bus.addr_max;
                    w_mask_nxt      = bus.cmp_mask;
                    w_done_nxt      = 1'b0;
                    w_pass_nxt      = 1'b0;
                    w_fail_addr_nxt = '0;
                    w_fail_elem_nxt = '0;
                    w_fail_data_nxt = '0;
                    w_err_nxt       = '0;
                end
            end
            S_RUN: begin
                w_active_nxt = 1'b1;
                if (r_elem == ELEM_END) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = '0;
                end
            end
            S_DRAIN: begin
                w_active_nxt = 1'b1;
                if (r_drain == DRAIN_W'(READ_LAT - 1)) begin
                    w_state_nxt  = S_DONE;
                    w_active_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_pass_nxt   = (w_err_nxt == '0);
                end else begin
                    w_drain_nxt = r_drain + DRAIN_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Issue an op on the start edge and on every RUN cycle until the march is exhausted
        if (w_state_nxt == S_RUN) begin
            w_active_nxt  = 1'b1;
            w_elem_nxt    = w_s_elem;
            w_addr_nxt    = w_s_addr;
            w_phase_nxt   = w_s_phase;
            w_addr0_nxt   = w_g_addr;
            w_csb0_nxt    = ~(NUM_SRAMS'(1) << w_g_sel);
            w_web0_nxt    = w_g_rd;
            w_din0_nxt    = w_g_rd ? '0 : {DATA_WIDTH{w_g_wbit}};
            w_op_rd_nxt   = w_g_rd;
            w_op_exp_nxt  = w_g_exp;
            w_op_elem_nxt = w_g_elem;
        end

        if ((r_state == S_RUN || r_state == S_DRAIN) && bus.abort) begin
            w_state_nxt  = S_IDLE;
            w_flush      = 1'b1;
            w_active_nxt = 1'b0;
            w_done_nxt   = 1'b0;
            w_csb0_nxt   = '1;
            w_web0_nxt   = 1'b1;
            w_addr0_nxt  = '0;
            w_din0_nxt   = '0;
            w_op_rd_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_elem      <= '0;
            r_addr      <= '0;
            r_phase     <= 1'b0;
            r_sel       <= '0;
            r_addr_max  <= '0;
            r_cmp_mask  <= '0;
            r_drain     <= '0;
            r_op_rd     <= 1'b0;
            r_op_exp    <= 1'b0;
            r_op_elem   <= '0;
            r_addr0     <= '0;
            r_din0      <= '0;
            r_web0      <= 1'b1;
            r_csb0      <= '1;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_data <= '0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_elem      <= w_elem_nxt;
            r_addr      <= w_addr_nxt;
            r_phase     <= w_phase_nxt;
            r_sel       <= w_sel_nxt;
            r_addr_max  <= w_amax_nxt;
            r_cmp_mask  <= w_mask_nxt;
            r_drain     <= w_drain_nxt;
            r_op_rd     <= w_op_rd_nxt;
            r_op_exp    <= w_op_exp_nxt;
            r_op_elem   <= w_op_elem_nxt;
            r_addr0     <= w_addr0_nxt;
            r_din0      <= w_din0_nxt;
            r_web0      <= w_web0_nxt;
            r_csb0      <= w_csb0_nxt;
            r_active    <= w_active_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_fail_elem <= w_fail_elem_nxt;
            r_fail_data <= w_fail_data_nxt;
            r_err_count <= w_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_pv <= '0;
        end else begin
            r_pv <= READ_LAT'({r_pv, r_op_rd});
        end
        r_pexp     <= READ_LAT'({r_pexp, r_op_exp});
        r_paddr[0] <= r_addr0;
        r_pelem[0] <= r_op_elem;
        for (int i = 1; i < int'(READ_LAT); i++) begin
            r_paddr[i] <= r_paddr[i-1];
            r_pelem[i] <= r_pelem[i-1];
        end
    end

    assign bus.addr0       = r_addr0;
    assign bus.din0        = r_din0;
    assign bus.web0        = r_web0;
    assign bus.wmask0      = '1;
    assign bus.csb0        = r_csb0;
    assign bus.csb1        = '1;
    assign bus.bist_active = r_active;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.fail_addr   = r_fail_addr;
    assign bus.fail_elem   = r_fail_elem;
    assign bus.fail_data   = r_fail_data;
    assign bus.err_count   = r_err_count;
endmodule
